ap_ctrl_hs_txn_recorder: RTL and testbench

- Synthesizable companion to the co-sim dataflow monitor; sits directly downstream of the DelayAndSum block-level ap_ctrl_hs handshake.
- Observes ap_start/ap_ready/ap_done/ap_continue passively.
- Turns each accepted/completed transaction into a timestamped record: ID, start-to-done latency, initiation interval.
- Records are buffered in a FIFO for a host/AXI-lite reader; running statistics are kept in hardware so on-board runs yield the same data as module_status CSV dumps.

---
 rtl/ap_txn_pkg.sv | 27 ++
 rtl/txn_sync_fifo.sv | 58 +++++
 rtl/ap_ctrl_hs_txn_recorder.sv | 165 ++++++++++++++++
 tb/tb_ap_ctrl_hs_txn_recorder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ap_txn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ap_txn_pkg
// Brief   : Shared constants and record layouts for the ap_ctrl_hs recorder.
// Revision: 1.0 - initial release
// ============================================================================
package ap_txn_pkg;

    localparam int DROP_W        = 16;
    localparam int CNT_W_DEFAULT = 32;
    localparam int ID_W_DEFAULT  = 16;

    // Host-visible layouts for the default build; the top re-derives them per parameter set.
    typedef struct packed {
        logic [ID_W_DEFAULT-1:0]  id;
        logic [CNT_W_DEFAULT-1:0] latency;
        logic [CNT_W_DEFAULT-1:0] interval;
    } txn_rec_t;

    typedef struct packed {
        logic [ID_W_DEFAULT-1:0]  id;
        logic [CNT_W_DEFAULT-1:0] ts;
        logic [CNT_W_DEFAULT-1:0] interval;
    } inflight_t;

endpackage
`default_nettype wire

// File: rtl/txn_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : txn_sync_fifo
// Brief   : Type-parameterised first-word-fall-through FIFO; push into a full
//           FIFO succeeds when a pop happens in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
module txn_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_empty,
    output logic o_full
);
    localparam int c_AW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [c_AW-1:0] r_wr;
    logic [c_AW-1:0] r_rd;
    logic [c_AW:0]   r_cnt;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (c_AW+1)'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/ap_ctrl_hs_txn_recorder.sv
`default_nettype none
// ============================================================================
// Module  : ap_ctrl_hs_txn_recorder
// Brief   : Passive ap_ctrl_hs observer producing per-transaction latency and
//           initiation-interval records plus running statistics.
// Revision: 1.0 - initial release
// ============================================================================
module ap_ctrl_hs_txn_recorder
    import ap_txn_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int ID_W     = 16,
    parameter int INFLIGHT = 4,
    parameter int DEPTH    = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              mon_ap_start,
    input  logic              mon_ap_ready,
    input  logic              mon_ap_done,
    input  logic              mon_ap_continue,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [ID_W-1:0]   rec_id,
    output logic [CNT_W-1:0]  rec_latency,
    output logic [CNT_W-1:0]  rec_interval,
    output logic [CNT_W-1:0]  txn_cnt,
    output logic [CNT_W-1:0]  max_latency,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              err_orphan_done,
    output logic              err_inflight_ovf,
    output logic              busy
);
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] ts;
        logic [CNT_W-1:0] interval;
    } ifl_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] latency;
        logic [CNT_W-1:0] interval;
    } rec_t;

    logic [CNT_W-1:0]  r_cyc;
    logic [CNT_W-1:0]  r_last_ts;
    logic              r_first;
    logic [ID_W-1:0]   r_next_id;
    logic [CNT_W-1:0]  r_txn_cnt;
    logic [CNT_W-1:0]  r_max_lat;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_err_orphan;
    logic              r_err_ovf;

    logic w_acc, w_cmp, w_bypass, w_ovf, w_orphan;
    logic w_ifl_push, w_ifl_pop, w_ifl_empty, w_ifl_full;
    logic w_rec_push, w_rec_pop, w_rec_drop, w_out_empty, w_out_full;
    logic [CNT_W-1:0] w_interval;
    ifl_t w_ifl_in, w_ifl_head;
    rec_t w_rec_in, w_rec_out;

    // clear discards any handshake seen in the same cycle
    assign w_acc      = enable && mon_ap_start && mon_ap_ready && !clear;
    assign w_cmp      = enable && mon_ap_done && mon_ap_continue && !clear;
    assign w_interval = r_first ? '0 : r_cyc - r_last_ts;

    assign w_ifl_pop  = w_cmp && !w_ifl_empty;
    assign w_bypass   = w_cmp && w_ifl_empty && w_acc;
    assign w_orphan   = w_cmp && w_ifl_empty && !w_acc;
    assign w_ovf      = w_acc && w_ifl_full && !w_cmp;
    assign w_ifl_push = w_acc && !w_bypass && !w_ovf;

    assign w_ifl_in.id       = r_next_id;
    assign w_ifl_in.ts       = r_cyc;
    assign w_ifl_in.interval = w_interval;

    always_comb begin
        w_rec_in = '0;
        if (w_bypass) begin
            w_rec_in.id       = r_next_id;
            w_rec_in.latency  = '0;
            w_rec_in.interval = w_interval;
        end else begin
            w_rec_in.id       = w_ifl_head.id;
            w_rec_in.latency  = r_cyc - w_ifl_head.ts;
            w_rec_in.interval = w_ifl_head.interval;
        end
    end

    assign w_rec_push = w_ifl_pop || w_bypass;
    assign w_rec_pop  = rec_valid && rec_ready;
    assign w_rec_drop = w_rec_push && w_out_full && !w_rec_pop;

    txn_sync_fifo #(.T(ifl_t), .DEPTH(INFLIGHT)) u_inflight (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .i_clear (clear),
        .i_push  (w_ifl_push),
        .i_data  (w_ifl_in),
        .i_pop   (w_ifl_pop),
        .o_data  (w_ifl_head),
        .o_empty (w_ifl_empty),
        .o_full  (w_ifl_full)
    );

    txn_sync_fifo #(.T(rec_t), .DEPTH(DEPTH)) u_records (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .i_clear (clear),
        .i_push  (w_rec_push && !w_rec_drop),
        .i_data  (w_rec_in),
        .i_pop   (w_rec_pop),
        .o_data  (w_rec_out),
        .o_empty (w_out_empty),
        .o_full  (w_out_full)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) r_cyc <= '0;
        else           r_cyc <= r_cyc + 1'b1;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || clear) begin
            r_last_ts    <= '0;
            r_first      <= 1'b1;
            r_next_id    <= '0;
            r_txn_cnt    <= '0;
            r_max_lat    <= '0;
            r_drop_cnt   <= '0;
            r_err_orphan <= 1'b0;
            r_err_ovf    <= 1'b0;
        end else begin
            if (w_acc) begin
                r_next_id <= r_next_id + 1'b1;
                r_last_ts <= r_cyc;
                r_first   <= 1'b0;
            end
            // statistics count every produced record, including ones the FIFO drops
            if (w_rec_push) begin
                if (r_txn_cnt != '1)            r_txn_cnt <= r_txn_cnt + 1'b1;
                if (w_rec_in.latency > r_max_lat) r_max_lat <= w_rec_in.latency;
            end
            if (w_rec_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_orphan) r_err_orphan <= 1'b1;
            if (w_ovf)    r_err_ovf    <= 1'b1;
        end
    end

    assign rec_valid        = !w_out_empty;
    assign rec_id           = rec_valid ? w_rec_out.id       : '0;
    assign rec_latency      = rec_valid ? w_rec_out.latency  : '0;
    assign rec_interval     = rec_valid ? w_rec_out.interval : '0;
    assign txn_cnt          = r_txn_cnt;
    assign max_latency      = r_max_lat;
    assign drop_cnt         = r_drop_cnt;
    assign err_orphan_done  = r_err_orphan;
    assign err_inflight_ovf = r_err_ovf;
    assign busy             = !w_ifl_empty;

endmodule
`default_nettype wire

// File: tb/tb_ap_ctrl_hs_txn_recorder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ap_ctrl_hs_txn_recorder
// Brief   : Directed + randomized bench against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ap_ctrl_hs_txn_recorder;
    localparam int CW = 8;
    localparam int IW = 8;
    localparam int NI = 4;
    localparam int ND = 16;
    localparam int CM = (1 << CW) - 1;
    localparam int IM = (1 << IW) - 1;

    logic ap_clk, ap_rst_n, enable, clear;
    logic mon_ap_start, mon_ap_ready, mon_ap_done, mon_ap_continue;
    logic rec_valid, rec_ready;
    logic [IW-1:0] rec_id;
    logic [CW-1:0] rec_latency, rec_interval, txn_cnt, max_latency;
    logic [15:0]   drop_cnt;
    logic err_orphan_done, err_inflight_ovf, busy;

    ap_ctrl_hs_txn_recorder #(.CNT_W(CW), .ID_W(IW), .INFLIGHT(NI), .DEPTH(ND)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable), .clear(clear),
        .mon_ap_start(mon_ap_start), .mon_ap_ready(mon_ap_ready),
        .mon_ap_done(mon_ap_done), .mon_ap_continue(mon_ap_continue),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
        .rec_latency(rec_latency), .rec_interval(rec_interval),
        .txn_cnt(txn_cnt), .max_latency(max_latency), .drop_cnt(drop_cnt),
        .err_orphan_done(err_orphan_done), .err_inflight_ovf(err_inflight_ovf),
        .busy(busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct { int id; int ts; int iv; } ent_t;
    typedef struct { int id; int lat; int iv; } rec_s;

    ent_t q_ifl[$];
    rec_s q_out[$];
    int m_cyc, m_next_id, m_last, m_txn, m_maxl, m_drop;
    bit m_first, m_eo, m_ev;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q_ifl.delete(); q_out.delete();
        m_next_id = 0; m_last = 0; m_first = 1;
        m_txn = 0; m_maxl = 0; m_drop = 0; m_eo = 0; m_ev = 0;
    endtask

    task automatic model_step();
        ent_t e;
        rec_s r;
        bit acc, cmp, pop, have, byp;
        int iv;
        if (!ap_rst_n) begin
            m_cyc = 0;
            model_clear();
            return;
        end
        if (clear) begin
            model_clear();
            m_cyc = (m_cyc + 1) & CM;
            return;
        end
        acc  = enable && mon_ap_start && mon_ap_ready;
        cmp  = enable && mon_ap_done && mon_ap_continue;
        pop  = (q_out.size() > 0) && rec_ready;
        have = 0;
        byp  = 0;
        iv   = m_first ? 0 : ((m_cyc - m_last) & CM);
        if (cmp) begin
            if (q_ifl.size() > 0) begin
                e = q_ifl.pop_front();
                r.id = e.id; r.lat = (m_cyc - e.ts) & CM; r.iv = e.iv;
                have = 1;
            end else if (acc) begin
                r.id = m_next_id; r.lat = 0; r.iv = iv;
                have = 1; byp = 1;
            end else begin
                m_eo = 1;
            end
        end
        if (acc) begin
            if (!byp) begin
                if (q_ifl.size() < NI) begin
                    e.id = m_next_id; e.ts = m_cyc; e.iv = iv;
                    q_ifl.push_back(e);
                end else begin
                    m_ev = 1;
                end
            end
            m_next_id = (m_next_id + 1) & IM;
            m_last    = m_cyc;
            m_first   = 0;
        end
        if (pop) void'(q_out.pop_front());
        if (have) begin
            if (m_txn < CM) m_txn++;
            if (r.lat > m_maxl) m_maxl = r.lat;
            if (q_out.size() < ND) q_out.push_back(r);
            else if (m_drop < 65535) m_drop++;
        end
        m_cyc = (m_cyc + 1) & CM;
    endtask

    task automatic compare_all();
        check("rec_valid", rec_valid, q_out.size() != 0);
        if (q_out.size() != 0) begin
            check("rec_id", rec_id, q_out[0].id);
            check("rec_latency", rec_latency, q_out[0].lat);
            check("rec_interval", rec_interval, q_out[0].iv);
        end
        check("txn_cnt", txn_cnt, m_txn);
        check("max_latency", max_latency, m_maxl);
        check("drop_cnt", drop_cnt, m_drop);
        check("err_orphan", err_orphan_done, m_eo);
        check("err_ovf", err_inflight_ovf, m_ev);
        check("busy", busy, q_ifl.size() != 0);
    endtask

    task automatic drive(input bit st, input bit rd, input bit dn, input bit ct);
        mon_ap_start = st; mon_ap_ready = rd; mon_ap_done = dn; mon_ap_continue = ct;
        @(posedge ap_clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 1);
    endtask

    initial begin
        ap_rst_n = 0; enable = 1; clear = 0; rec_ready = 1;
        mon_ap_start = 0; mon_ap_ready = 0; mon_ap_done = 0; mon_ap_continue = 1;
        m_cyc = 0;
        model_clear();
        idle(3);
        check("reset_valid", rec_valid, 0);
        check("reset_txn", txn_cnt, 0);
        ap_rst_n = 1;
        idle(2);

        // single transaction: latency 15
        drive(1, 1, 0, 1);
        idle(14);
        drive(0, 0, 1, 1);
        check("single_id", rec_id, 0);
        check("single_lat", rec_latency, 15);
        check("single_iv", rec_interval, 0);
        check("single_txn", txn_cnt, 1);
        check("single_max", max_latency, 15);
        idle(2);

        // pipelined: accepts 4 apart, each latency 20
        for (int k = 0; k < 29; k++) begin
            drive(k == 0 || k == 4 || k == 8, 1, k == 20 || k == 24 || k == 28, 1);
            if (k == 1)  check("pipe_busy", busy, 1);
            if (k == 20) check("pipe_lat", rec_latency, 20);
        end
        check("pipe_idle", busy, 0);

        // same-cycle bypass with empty queue, then with one in flight
        drive(1, 1, 1, 1);
        check("byp_lat", rec_latency, 0);
        check("byp_orphan", err_orphan_done, 0);
        idle(2);
        drive(1, 1, 0, 1);
        idle(9);
        drive(1, 1, 1, 1);
        check("byp2_lat", rec_latency, 10);
        check("byp2_busy", busy, 1);
        drive(0, 0, 1, 1);

        // overflow then orphan
        for (int k = 0; k < 5; k++) drive(1, 1, 0, 1);
        check("ovf_flag", err_inflight_ovf, 1);
        idle(4);
        for (int k = 0; k < 4; k++) drive(0, 0, 1, 1);
        drive(0, 0, 1, 1);
        check("orphan_flag", err_orphan_done, 1);
        idle(6);

        // back-pressure: 18 completions into a 16-deep FIFO
        clear = 1; idle(1); clear = 0;
        rec_ready = 0;
        for (int k = 0; k < 18; k++) drive(1, 1, 1, 1);
        check("bp_drop", drop_cnt, 2);
        check("bp_txn", txn_cnt, 18);
        rec_ready = 1;
        idle(17);

        // counter wrap: accept at 250, done at 4
        clear = 1; idle(1); clear = 0;
        for (int k = 0; k < 300 && m_cyc != 250; k++) idle(1);
        drive(1, 1, 0, 1);
        idle(9);
        drive(0, 0, 1, 1);
        check("wrap_lat", rec_latency, 10);

        // reset mid-transaction
        drive(1, 1, 0, 1);
        ap_rst_n = 0; idle(1);
        check("rst_busy", busy, 0);
        check("rst_txn", txn_cnt, 0);
        ap_rst_n = 1;
        drive(1, 1, 1, 1);
        check("rst_id", rec_id, 0);
        check("rst_iv", rec_interval, 0);
        idle(2);

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            enable    = ($urandom % 16) != 0;
            clear     = ($urandom % 250) == 0;
            ap_rst_n  = ($urandom % 900) != 0;
            rec_ready = ($urandom % 4) != 0;
            drive(($urandom % 3) == 0, ($urandom % 5) != 0,
                  ($urandom % 3) == 0, ($urandom % 4) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
